apb_protocol_checker: RTL and testbench

Synthesizable, parametrised APB3/APB4 bus protocol checker and transfer monitor. Sits passively on one APB segment (requester plus `NUM_SLAVES` completers) and tracks the IDLE/SETUP/ACCESS phase sequence. It flags protocol violations into sticky error bits and keeps saturating transfer statistics. It drives nothing on the bus and is used both in silicon (debug status) and in the VIP environment.

---
 rtl/apb_protocol_checker.sv | 184 ++++++++++++++++++
 tb/tb_apb_protocol_checker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_protocol_checker.sv
// Passive APB3/APB4 segment monitor: tracks the IDLE/SETUP/ACCESS phases, latches
// protocol violations into sticky error bits and keeps saturating transfer statistics.
module apb_protocol_checker #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter int TIMEOUT    = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET_N,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [NUM_SLAVES-1:0]   PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic                    PREADY,
  input  logic                    PSLVERR,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    clr_i,
  output logic [1:0]              state_o,
  output logic [7:0]              err_o,
  output logic                    err_pulse_o,
  output logic [CNT_WIDTH-1:0]    wr_cnt_o,
  output logic [CNT_WIDTH-1:0]    rd_cnt_o,
  output logic [CNT_WIDTH-1:0]    slverr_cnt_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);
  localparam logic [NUM_SLAVES-1:0] SEL_ONE = NUM_SLAVES'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [NUM_SLAVES-1:0]   sel_q, sel_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   strb_q, strb_d;
  logic [7:0]              waitCnt_q, waitCnt_d;
  logic                    cmpl_q, cmpl_d;
  logic [6:0]              err_q, err_d;
  logic                    pulse_q, pulse_d;
  logic [CNT_WIDTH-1:0]    wrCnt_q, wrCnt_d;
  logic [CNT_WIDTH-1:0]    rdCnt_q, rdCnt_d;
  logic [CNT_WIDTH-1:0]    slvCnt_q, slvCnt_d;

  logic [6:0] newErr;
  logic       incWr, incRd, incSlv;
  logic       selected, multiSel, evalIdle;
  logic       unusedPrdata;

  assign selected     = |PSEL;
  assign multiSel     = |(PSEL & (PSEL - SEL_ONE));
  assign unusedPrdata = ^PRDATA;

  function automatic logic [CNT_WIDTH-1:0] satInc(input logic [CNT_WIDTH-1:0] base,
                                                  input logic inc);
    return (inc && (base != '1)) ? base + CNT_WIDTH'(1) : base;
  endfunction

  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      sel_q     <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      waitCnt_q <= '0;
      cmpl_q    <= 1'b0;
      err_q     <= '0;
      pulse_q   <= 1'b0;
      wrCnt_q   <= '0;
      rdCnt_q   <= '0;
      slvCnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      waitCnt_q <= waitCnt_d;
      cmpl_q    <= cmpl_d;
      err_q     <= err_d;
      pulse_q   <= pulse_d;
      wrCnt_q   <= wrCnt_d;
      rdCnt_q   <= rdCnt_d;
      slvCnt_q  <= slvCnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    waitCnt_d = waitCnt_q;
    cmpl_d    = 1'b0;
    newErr    = '0;
    incWr     = 1'b0;
    incRd     = 1'b0;
    incSlv    = 1'b0;
    evalIdle  = 1'b0;
    newErr[0] = multiSel;

    unique case (state_q)
      IDLE: evalIdle = 1'b1;
      SETUP: begin
        if (PENABLE && (PSEL == sel_q)) begin
          state_d = ACCESS;
        end else begin
          newErr[2] = 1'b1;
          evalIdle  = 1'b1;
        end
      end
      ACCESS: begin
        if ((PADDR != addr_q) || (PSEL != sel_q) || (PWRITE != write_q))
          newErr[3] = 1'b1;
        if (write_q && ((PWDATA != wdata_q) || (PSTRB != strb_q)))
          newErr[3] = 1'b1;
        if (PREADY) begin
          state_d   = IDLE;
          cmpl_d    = 1'b1;
          waitCnt_d = '0;
          incWr     = PWRITE;
          incRd     = !PWRITE;
          incSlv    = PSLVERR;
        end else if (waitCnt_q != TIMEOUT_W) begin
          // Counter parks at TIMEOUT so the timeout error fires only once per transfer
          waitCnt_d = waitCnt_q + 8'd1;
          if (waitCnt_d == TIMEOUT_W)
            newErr[4] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (evalIdle) begin
      if (PENABLE) begin
        // Enable held straight after a completion is reported as ENABLE_HOLD only
        state_d = IDLE;
        if (cmpl_q) newErr[6] = 1'b1;
        else        newErr[1] = 1'b1;
      end else if (selected) begin
        state_d = SETUP;
        addr_d  = PADDR;
        sel_d   = PSEL;
        write_d = PWRITE;
        wdata_d = PWDATA;
        strb_d  = PSTRB;
        if (!PWRITE && (PSTRB != '0))
          newErr[5] = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    err_d    = (clr_i ? 7'd0 : err_q) | newErr;
    pulse_d  = |newErr;
    wrCnt_d  = satInc(clr_i ? '0 : wrCnt_q, incWr);
    rdCnt_d  = satInc(clr_i ? '0 : rdCnt_q, incRd);
    slvCnt_d = satInc(clr_i ? '0 : slvCnt_q, incSlv);
  end

  assign state_o      = state_q;
  assign err_o        = {1'b0, err_q};
  assign err_pulse_o  = pulse_q;
  assign wr_cnt_o     = wrCnt_q;
  assign rd_cnt_o     = rdCnt_q;
  assign slverr_cnt_o = slvCnt_q;

endmodule

// File: tb/tb_apb_protocol_checker.sv
// Scoreboard bench for apb_protocol_checker: every driven cycle pushes its expected
// post-edge outputs, and a monitor pops and compares them after the next rising edge.
module tb_apb_protocol_checker;

  localparam int TO  = 4;
  localparam int CW  = 4;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic          PCLK;
  logic          PRESET_N;
  logic [31:0]   PADDR;
  logic [3:0]    PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [31:0]   PWDATA;
  logic [3:0]    PSTRB;
  logic          PREADY;
  logic          PSLVERR;
  logic [31:0]   PRDATA;
  logic          clrIn;
  logic [1:0]    stateOut;
  logic [7:0]    errOut;
  logic          pulseOut;
  logic [CW-1:0] wrCnt, rdCnt, slvCnt;

  typedef struct {
    logic [1:0]    st;
    logic [7:0]    err;
    logic          pulse;
    logic [CW-1:0] wr;
    logic [CW-1:0] rd;
    logic [CW-1:0] slv;
  } exp_t;

  exp_t expQ[$];

  logic [7:0]    expErr;
  logic [CW-1:0] expWr, expRd, expSlv;
  int            checks;
  int            fails;

  apb_protocol_checker #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(4), .TIMEOUT(TO), .CNT_WIDTH(CW)
  ) dut (
    .PCLK(PCLK), .PRESET_N(PRESET_N), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .PRDATA(PRDATA), .clr_i(clrIn), .state_o(stateOut), .err_o(errOut),
    .err_pulse_o(pulseOut), .wr_cnt_o(wrCnt), .rd_cnt_o(rdCnt), .slverr_cnt_o(slvCnt)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [CW-1:0] bump(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  // Expected-value bookkeeping lives here so scenarios only describe the bus and the events
  task automatic applyStimulus(input logic [3:0] sel, input logic en, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input logic rdy, input logic serr,
                               input logic clr, input logic [1:0] expSt,
                               input logic [7:0] newErr, input logic cmpl);
    exp_t e;
    @(negedge PCLK);
    PSEL = sel; PENABLE = en; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    PSTRB = strb; PREADY = rdy; PSLVERR = serr; clrIn = clr;
    PRDATA = $urandom;
    if (clr) begin
      expErr = 8'h00; expWr = '0; expRd = '0; expSlv = '0;
    end
    expErr = expErr | newErr;
    if (cmpl) begin
      if (wr) expWr = bump(expWr);
      else    expRd = bump(expRd);
      if (serr) expSlv = bump(expSlv);
    end
    e.st = expSt; e.err = expErr; e.pulse = |newErr;
    e.wr = expWr; e.rd = expRd; e.slv = expSlv;
    expQ.push_back(e);
  endtask

  task automatic idleCycle();
    applyStimulus(4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, S_IDLE, 8'h00, 1'b0);
  endtask

  task automatic doXfer(input logic [3:0] sel, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb, input int waits,
                        input logic serr, input int glitchAt, input logic clrEnd);
    logic [7:0] e;
    e = (!wr && strb != 4'h0) ? 8'h20 : 8'h00;
    applyStimulus(sel, 1'b0, wr, addr, data, strb, 1'b0, 1'b0, 1'b0, S_SETUP, e, 1'b0);
    applyStimulus(sel, 1'b1, wr, addr, data, strb, 1'b0, 1'b0, 1'b0, S_ACCESS, 8'h00, 1'b0);
    for (int i = 1; i <= waits; i++) begin
      e = (i == TO) ? 8'h10 : 8'h00;
      if (i == glitchAt)
        applyStimulus(sel, 1'b1, wr, addr + 32'h4, data, strb, 1'b0, 1'b0, 1'b0, S_ACCESS, e | 8'h08, 1'b0);
      else
        applyStimulus(sel, 1'b1, wr, addr, data, strb, 1'b0, 1'b0, 1'b0, S_ACCESS, e, 1'b0);
    end
    applyStimulus(sel, 1'b1, wr, addr, data, strb, 1'b1, serr, clrEnd, S_IDLE, 8'h00, 1'b1);
  endtask

  task automatic driveIdle();
    PSEL = 4'h0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    PSTRB = 4'h0; PREADY = 1'b0; PSLVERR = 1'b0; clrIn = 1'b0; PRDATA = '0;
  endtask

  always @(posedge PCLK) begin
    #1;
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkOutput("state",  32'(stateOut), 32'(e.st));
      checkOutput("err",    32'(errOut),   32'(e.err));
      checkOutput("pulse",  32'(pulseOut), 32'(e.pulse));
      checkOutput("wr_cnt", 32'(wrCnt),    32'(e.wr));
      checkOutput("rd_cnt", 32'(rdCnt),    32'(e.rd));
      checkOutput("slv_cnt",32'(slvCnt),   32'(e.slv));
    end
  end

  initial begin
    checks = 0; fails = 0;
    expErr = 8'h00; expWr = '0; expRd = '0; expSlv = '0;
    driveIdle();
    PRESET_N = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    checkOutput("rst_state", 32'(stateOut), 32'd0);
    checkOutput("rst_err",   32'(errOut),   32'd0);
    checkOutput("rst_pulse", 32'(pulseOut), 32'd0);
    checkOutput("rst_wr",    32'(wrCnt),    32'd0);
    @(negedge PCLK);
    PRESET_N = 1'b1;

    $display("[TB] write with two wait states");
    doXfer(4'b0010, 1'b1, 32'h10, 32'hCAFE_0001, 4'hF, 2, 1'b0, 0, 1'b0);
    idleCycle();

    $display("[TB] zero-wait read with PSLVERR");
    doXfer(4'b0100, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b1, 0, 1'b0);
    idleCycle();

    $display("[TB] address glitch in second wait cycle");
    doXfer(4'b0010, 1'b1, 32'h10, 32'h1234_5678, 4'h3, 3, 1'b0, 2, 1'b0);
    idleCycle();

    $display("[TB] timeout with six wait cycles");
    doXfer(4'b1000, 1'b0, 32'h40, 32'h0, 4'h0, 6, 1'b0, 0, 1'b0);
    idleCycle();

    $display("[TB] multi-select with enable in idle");
    applyStimulus(4'b0011, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, S_IDLE, 8'h03, 1'b0);
    idleCycle();

    $display("[TB] strobes on read, then setup without access");
    doXfer(4'b0001, 1'b0, 32'h80, 32'h0, 4'hF, 0, 1'b0, 0, 1'b0);
    idleCycle();
    applyStimulus(4'b0001, 1'b0, 1'b1, 32'h84, 32'h5, 4'h1, 1'b0, 1'b0, 1'b0, S_SETUP, 8'h00, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, S_IDLE, 8'h04, 1'b0);

    $display("[TB] enable held after completion, then back-to-back pair");
    doXfer(4'b0100, 1'b1, 32'h90, 32'hAA, 4'h1, 0, 1'b0, 0, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, S_IDLE, 8'h40, 1'b0);
    idleCycle();
    doXfer(4'b0100, 1'b1, 32'h94, 32'hBB, 4'hF, 1, 1'b0, 0, 1'b0);
    doXfer(4'b0100, 1'b0, 32'h98, 32'h0, 4'h0, 0, 1'b0, 0, 1'b0);
    doXfer(4'b0100, 1'b0, 32'h9C, 32'h0, 4'h0, 0, 1'b0, 0, 1'b0);

    $display("[TB] clear coinciding with a read completion");
    doXfer(4'b0001, 1'b0, 32'hA0, 32'h0, 4'h0, 0, 1'b0, 0, 1'b1);
    @(posedge PCLK); #2;
    checkOutput("clr_rd",  32'(rdCnt),  32'd1);
    checkOutput("clr_err", 32'(errOut), 32'd0);
    checkOutput("clr_wr",  32'(wrCnt),  32'd0);
    idleCycle();

    $display("[TB] write counter saturation");
    for (int i = 0; i < 16; i++)
      doXfer(4'b0010, 1'b1, 32'hB0, 32'(i), 4'hF, 0, 1'b0, 0, 1'b0);
    @(posedge PCLK); #2;
    checkOutput("sat_wr", 32'(wrCnt), 32'hF);
    idleCycle();

    $display("[TB] reset during a transfer");
    applyStimulus(4'b1000, 1'b0, 1'b1, 32'hC0, 32'h77, 4'hF, 1'b0, 1'b0, 1'b0, S_SETUP, 8'h00, 1'b0);
    applyStimulus(4'b1000, 1'b1, 1'b1, 32'hC0, 32'h77, 4'hF, 1'b0, 1'b0, 1'b0, S_ACCESS, 8'h00, 1'b0);
    applyStimulus(4'b1000, 1'b1, 1'b1, 32'hC0, 32'h77, 4'hF, 1'b0, 1'b0, 1'b0, S_ACCESS, 8'h00, 1'b0);
    @(posedge PCLK); #2;
    PRESET_N = 1'b0;
    #1;
    checkOutput("mid_rst_state", 32'(stateOut), 32'd0);
    checkOutput("mid_rst_wr",    32'(wrCnt),    32'd0);
    checkOutput("mid_rst_err",   32'(errOut),   32'd0);
    expErr = 8'h00; expWr = '0; expRd = '0; expSlv = '0;
    driveIdle();
    @(negedge PCLK);
    PRESET_N = 1'b1;
    applyStimulus(4'b1000, 1'b1, 1'b1, 32'hC0, 32'h77, 4'hF, 1'b1, 1'b0, 1'b0, S_IDLE, 8'h02, 1'b0);
    idleCycle();
    doXfer(4'b0001, 1'b1, 32'hD0, 32'h99, 4'hF, 0, 1'b0, 0, 1'b0);
    idleCycle();

    for (int i = 0; i < 10; i++) begin
      if (expQ.size() == 0) break;
      @(posedge PCLK); #2;
    end
    checkOutput("drain", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
